cond_flag_unit: RTL and testbench

//  Counterpart of the ALU flag interface: stores the ALU's {N,Z,C,V} flags and sends carry-in values back to the ALU.

---
 rtl/cond_pkg.sv | 26 ++
 rtl/cond_flag_unit_if.sv | 30 +++
 rtl/cond_eval.sv | 31 +++
 rtl/cond_flag_unit.sv | 69 ++++++
 tb/tb_cond_flag_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: ARM condition codes, NZCV bit indices and FlagW masks shared by the condition/flag logic.
package cond_pkg;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;
  typedef logic [3:0] nzcv_t;
endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: decoder/ALU side bundle of cond_flag_unit; shadow-stack signals exist only with FLAG_SHADOW_EN.
interface cond_flag_unit_if;
  import cond_pkg::*;
  logic Valid, Stall;
  logic [3:0] Cond;
  logic [1:0] FlagW;
  logic PCS, RegW, MemW, NoWrite;
  nzcv_t ALUFlags;
  logic ShCarry, ShCarryVld;
  logic CondEx, PCSrc, RegWrite, MemWrite;
  logic carryFlag, carryFlag2;
  nzcv_t Flags;
`ifdef FLAG_SHADOW_EN
  logic ExcEntry, ExcReturn, ShadowOvf, ShadowUnf;
`endif
  modport master (
    output Valid, Stall, Cond, FlagW, PCS, RegW, MemW, NoWrite, ALUFlags, ShCarry, ShCarryVld,
    input CondEx, PCSrc, RegWrite, MemWrite, carryFlag, carryFlag2, Flags
`ifdef FLAG_SHADOW_EN
    , output ExcEntry, ExcReturn, input ShadowOvf, ShadowUnf
`endif
  );
  modport slave (
    input Valid, Stall, Cond, FlagW, PCS, RegW, MemW, NoWrite, ALUFlags, ShCarry, ShCarryVld,
    output CondEx, PCSrc, RegWrite, MemWrite, carryFlag, carryFlag2, Flags
`ifdef FLAG_SHADOW_EN
    , input ExcEntry, ExcReturn, output ShadowOvf, ShadowUnf
`endif
  );
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition check of a 4-bit condition field against NZCV; NV never passes.
module cond_eval
  import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  nzcv_t      flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign {n, z, c, v} = {flags[FLAG_N], flags[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
    always_comb begin
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, condition gating of Execute controls and carry-in selection.
// Optional exception flag-save LIFO when FLAG_SHADOW_EN is defined.
module cond_flag_unit
  import cond_pkg::*;
#(
    parameter nzcv_t RESET_FLAGS = 4'b0000
`ifdef FLAG_SHADOW_EN
    , parameter int SHADOW_DEPTH = 2
`endif
) (
    input logic CLK,
    input logic RESETN,
    cond_flag_unit_if.slave bus
);
    nzcv_t flags, flags_wr, flags_nxt;
    logic pass, commit;
    cond_eval u_eval (
        .cond   (bus.Cond),
        .flags  (flags),
        .cond_ex(pass)
    );
    assign bus.CondEx     = bus.Valid & pass;
    assign bus.PCSrc      = bus.PCS & bus.CondEx;
    assign bus.RegWrite   = bus.RegW & bus.CondEx & !bus.NoWrite;
    assign bus.MemWrite   = bus.MemW & bus.CondEx;
    assign bus.carryFlag  = flags[FLAG_C];
    assign bus.carryFlag2 = bus.ShCarryVld ? bus.ShCarry : flags[FLAG_C];
    assign bus.Flags      = flags;
    assign commit = bus.CondEx & !bus.Stall;
    assign flags_wr = {
        commit & bus.FlagW[1] ? bus.ALUFlags[3:2] : flags[3:2],
        commit & bus.FlagW[0] ? bus.ALUFlags[1:0] : flags[1:0]
    };
`ifdef FLAG_SHADOW_EN
    localparam int PW = $clog2(SHADOW_DEPTH + 1);
    nzcv_t stk [2**PW];
    logic [PW-1:0] ptr;
    logic push, pop, full, empty, ovf, unf;
    // Entry and return together cancel each other; the FlagW write still goes ahead.
    assign push  = !bus.Stall & bus.ExcEntry & !bus.ExcReturn;
    assign pop   = !bus.Stall & bus.ExcReturn & !bus.ExcEntry;
    assign full  = ptr == PW'(SHADOW_DEPTH);
    assign empty = ptr == '0;
    assign flags_nxt = pop & !empty ? stk[ptr - 1'b1] : flags_wr;
    assign bus.ShadowOvf = ovf;
    assign bus.ShadowUnf = unf;
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ptr <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push & !full) ptr <= ptr + 1'b1;
            if (pop & !empty) ptr <= ptr - 1'b1;
            if (push & full) ovf <= 1'b1;
            if (pop & empty) unf <= 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (push & !full) stk[ptr] <= flags;
    end
`else
    assign flags_nxt = flags_wr;
`endif
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) flags <= RESET_FLAGS;
        else flags <= flags_nxt;
    end
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed vector table plus stall, async-reset and (FLAG_SHADOW_EN) shadow-stack sequences.
module tb_cond_flag_unit;
    import cond_pkg::*;
    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;
    cond_flag_unit_if bus ();
    cond_flag_unit dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .bus   (bus)
    );
    int nvec = 0;
    int nmis = 0;
    typedef struct {
        logic [3:0] cond;
        logic valid, stall;
        logic [1:0] fw;
        logic pcs, regw, memw, nw;
        logic [3:0] alu;
        logic shc, shv;
        logic cex, pcsrc, rw, mw, c, c2;
        logic [3:0] fl;
    } vec_t;
    vec_t tbl[$];
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic idle();
        bus.Valid = 0; bus.Stall = 0; bus.Cond = COND_AL; bus.FlagW = 0;
        bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.NoWrite = 0;
        bus.ALUFlags = 0; bus.ShCarry = 0; bus.ShCarryVld = 0;
`ifdef FLAG_SHADOW_EN
        bus.ExcEntry = 0; bus.ExcReturn = 0;
`endif
    endtask
    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask
    task automatic write_flags(input logic [3:0] f);
        @(negedge CLK);
        idle();
        bus.Valid = 1; bus.FlagW = 2'b11; bus.ALUFlags = f;
        edge_step();
    endtask
    initial begin
        //             cond     v  s  fw     pcs rw mw nw alu      shc shv  cex pc rw mw c  c2 flags-after
        tbl.push_back('{COND_EQ, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 0, 0, 4'b0000});
        tbl.push_back('{COND_AL, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   1, 0, 1, 0, 0, 0, 4'b0000});
        tbl.push_back('{COND_AL, 1, 0, 2'b11, 0, 1, 0, 0, 4'b0110, 0, 0,   1, 0, 1, 0, 0, 0, 4'b0110});
        tbl.push_back('{COND_EQ, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   1, 0, 1, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_HI, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_LS, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   1, 0, 1, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_AL, 1, 0, 2'b11, 0, 0, 0, 0, 4'b1001, 0, 0,   1, 0, 0, 0, 1, 1, 4'b1001});
        tbl.push_back('{COND_AL, 1, 0, 2'b10, 0, 0, 0, 0, 4'b0110, 0, 0,   1, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_GE, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_LT, 1, 0, 2'b00, 0, 1, 0, 0, 4'b0000, 0, 0,   1, 0, 1, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_AL, 0, 0, 2'b11, 1, 1, 1, 0, 4'b1111, 0, 0,   0, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_NV, 1, 0, 2'b11, 1, 0, 1, 0, 4'b1111, 0, 0,   0, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_AL, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 1,   1, 0, 0, 0, 0, 1, 4'b0101});
        tbl.push_back('{COND_AL, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 1, 0,   1, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_AL, 1, 0, 2'b00, 1, 1, 1, 1, 4'b0000, 0, 0,   1, 1, 0, 1, 0, 0, 4'b0101});
        tbl.push_back('{COND_AL, 1, 1, 2'b11, 1, 1, 0, 0, 4'b0000, 0, 0,   1, 1, 1, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_CS, 1, 0, 2'b11, 0, 1, 0, 0, 4'b1111, 0, 0,   0, 0, 0, 0, 0, 0, 4'b0101});
        tbl.push_back('{COND_CC, 1, 0, 2'b01, 0, 1, 0, 0, 4'b0010, 0, 0,   1, 0, 1, 0, 0, 0, 4'b0110});
        tbl.push_back('{COND_MI, 1, 0, 2'b00, 0, 0, 1, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_PL, 1, 0, 2'b00, 0, 0, 1, 0, 4'b0000, 0, 0,   1, 0, 0, 1, 1, 1, 4'b0110});
        tbl.push_back('{COND_VS, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_VC, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 1,   1, 0, 0, 0, 1, 0, 4'b0110});
        tbl.push_back('{COND_GT, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_LE, 1, 0, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0,   1, 1, 0, 0, 1, 1, 4'b0110});
        tbl.push_back('{COND_NE, 1, 0, 2'b11, 0, 0, 0, 0, 4'b1111, 0, 0,   0, 0, 0, 0, 1, 1, 4'b0110});
        idle();
        #2;
        chk("reset_flags", bus.Flags, 4'b0000);
`ifdef FLAG_SHADOW_EN
        chk("reset_ovf", {3'b0, bus.ShadowOvf}, 4'b0);
        chk("reset_unf", {3'b0, bus.ShadowUnf}, 4'b0);
`endif
        @(negedge CLK);
        RESETN = 1;
        foreach (tbl[i]) begin
            @(negedge CLK);
            bus.Cond = tbl[i].cond; bus.Valid = tbl[i].valid; bus.Stall = tbl[i].stall;
            bus.FlagW = tbl[i].fw; bus.PCS = tbl[i].pcs; bus.RegW = tbl[i].regw;
            bus.MemW = tbl[i].memw; bus.NoWrite = tbl[i].nw; bus.ALUFlags = tbl[i].alu;
            bus.ShCarry = tbl[i].shc; bus.ShCarryVld = tbl[i].shv;
            #1;
            chk($sformatf("v%0d_outs", i),
                {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite},
                {tbl[i].cex, tbl[i].pcsrc, tbl[i].rw, tbl[i].mw});
            chk($sformatf("v%0d_carry", i), {2'b0, bus.carryFlag, bus.carryFlag2},
                {2'b0, tbl[i].c, tbl[i].c2});
            edge_step();
            chk($sformatf("v%0d_flags", i), bus.Flags, tbl[i].fl);
        end
        // held instruction: frozen while stalled, commits exactly once after release
        @(negedge CLK);
        idle();
        bus.Valid = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111; bus.Stall = 1;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            chk($sformatf("stall%0d_flags", k), bus.Flags, 4'b0110);
        end
        @(negedge CLK);
        bus.Stall = 0;
        edge_step();
        chk("stall_commit", bus.Flags, 4'b1111);
        @(negedge CLK);
        idle();
        bus.FlagW = 2'b11;
        edge_step();
        chk("stall_once", bus.Flags, 4'b1111);
        // asynchronous reset between clock edges
        #2;
        RESETN = 0;
        #1;
        chk("async_reset", bus.Flags, 4'b0000);
        @(negedge CLK);
        RESETN = 1;
`ifdef FLAG_SHADOW_EN
        write_flags(4'b0100);
        @(negedge CLK); idle(); bus.ExcEntry = 1; edge_step();
        write_flags(4'b1000);
        @(negedge CLK); idle(); bus.ExcEntry = 1; edge_step();
        chk("push2_ovf", {3'b0, bus.ShadowOvf}, 4'b0);
        @(negedge CLK); idle(); bus.ExcEntry = 1; edge_step();
        chk("push3_ovf", {3'b0, bus.ShadowOvf}, 4'b1);
        write_flags(4'b0011);
        @(negedge CLK); idle(); bus.ExcReturn = 1;
        bus.Valid = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
        edge_step();
        chk("pop1_flags", bus.Flags, 4'b1000);
        @(negedge CLK); idle(); bus.ExcReturn = 1; edge_step();
        chk("pop2_flags", bus.Flags, 4'b0100);
        chk("pop2_unf", {3'b0, bus.ShadowUnf}, 4'b0);
        @(negedge CLK); idle(); bus.ExcReturn = 1; edge_step();
        chk("pop3_flags", bus.Flags, 4'b0100);
        chk("pop3_unf", {3'b0, bus.ShadowUnf}, 4'b1);
        @(negedge CLK); idle(); bus.ExcEntry = 1; bus.ExcReturn = 1;
        bus.Valid = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1010;
        edge_step();
        chk("both_flags", bus.Flags, 4'b1010);
        @(negedge CLK); idle(); bus.ExcEntry = 1;
        bus.Valid = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0001;
        edge_step();
        chk("push_wr_flags", bus.Flags, 4'b0001);
        @(negedge CLK); idle(); bus.ExcReturn = 1; edge_step();
        chk("pop_prewrite", bus.Flags, 4'b1010);
        @(negedge CLK); idle(); bus.ExcEntry = 1; edge_step();
        #2;
        RESETN = 0;
        #1;
        chk("shadow_rst_flags", bus.Flags, 4'b0000);
        chk("shadow_rst_sticky", {2'b0, bus.ShadowOvf, bus.ShadowUnf}, 4'b0);
        @(negedge CLK);
        RESETN = 1;
        @(negedge CLK); idle(); bus.ExcReturn = 1; edge_step();
        chk("rst_ptr_unf", {3'b0, bus.ShadowUnf}, 4'b1);
        chk("rst_ptr_flags", bus.Flags, 4'b0000);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
